ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- W, 16, control-field width.
- STAGES, 4, number of pipeline registers; range 2..6; stage 1 is Execute.
- CLR_MASK, {W{1'b1}}, bits zeroed on flush or bubble; 0-bits are never zeroed.
- MD_BIT, 0, index of the multicycle (mul/div) flag within the field.
- MD_CYCLES, 32, stage-1 occupancy of a multicycle entry; range 2..64.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; rising edge.
- rst, in, 1, asynchronous active-high reset.
- ctrl_d, in, W, decode-stage control field.
- valid_d, in, 1, ctrl_d holds a real instruction.
- stall, in, STAGES, bit k-1 holds the stage-k register.
- flush, in, STAGES, bit k-1 clears the stage-k register.
- ctrl_q, out, STAGES*W, stage k field at [k*W-1:(k-1)*W].
- valid_q, out, STAGES, bit k-1 is the stage-k valid.
- md_stall, out, 1, request to hold stage 0 and stage 1 (multicycle in progress).
- md_busy, out, 1, multicycle FSM is in BUSY.
REQ-003 There SHALL be one clock and one reset; reset SHALL be asynchronous and active-high.

Function
REQ-004 The stage-k source SHALL be stage k-1; the stage-0 source SHALL be ctrl_d/valid_d.
REQ-005 The stage-k hold SHALL be: hold_k = stall[k-1], plus md_stall for k=1.
REQ-006 Flush SHALL override hold. On flush[k-1]:
- valid_q[k-1] <= 0.
- CLR_MASK bits <= 0.
- Unmasked bits load the source if not held, else keep their value.
REQ-007 When no flush and hold_k: stage k SHALL retain its field and its valid.
REQ-008 Automatic bubble: when hold_{k-1} and !hold_k and no flush at stage k (k≥2), stage k SHALL load:
- valid = 0.
- CLR_MASK bits = 0.
- Unmasked bits from stage k-1.
REQ-009 Otherwise stage k SHALL load the source field and valid.
REQ-010 Stall inputs SHALL NOT propagate backward; md_stall is the only upstream hold the block generates.
REQ-011 The multicycle FSM SHALL have states IDLE and BUSY and a counter cnt, $clog2(MD_CYCLES) bits wide.
REQ-012 md_load SHALL mean: stage 1 loads, per REQ-009, an entry with valid_d=1 and ctrl_d[MD_BIT]=1, and flush[0]=0.
REQ-013 IDLE with md_load SHALL go to BUSY with cnt <= MD_CYCLES-1.
REQ-014 In BUSY, cnt SHALL decrement each cycle regardless of stall[0].
REQ-015 In BUSY with cnt==0, the next state SHALL be BUSY with cnt reloaded if md_load, else IDLE.
REQ-016 md_stall SHALL equal (BUSY && cnt!=0); md_busy SHALL equal BUSY.
REQ-017 A multicycle entry SHALL occupy stage 1 for exactly MD_CYCLES cycles, extended only by stall[0].
REQ-018 flush[0] in BUSY SHALL force IDLE, cnt <= 0, with md_stall low from the next cycle.
REQ-019 Outputs SHALL be registered, except md_stall, which is decoded from state and cnt.

Reset
REQ-020 While rst=1, the following SHALL hold asynchronously:
- ctrl_q = 0, valid_q = 0.
- FSM = IDLE, cnt = 0.
- md_stall = 0, md_busy = 0.
REQ-021 Reset asserted mid-multicycle SHALL abort the operation, with no residual stall after release.
REQ-022 The first edge after reset release SHALL behave as a normal load.

Verification
Parameters for all scenarios: W=8, STAGES=4, CLR_MASK=8'h0F, MD_BIT=7, MD_CYCLES=4.
REQ-023 Plain flow: ctrl_d=8'h35, valid_d=1 for one cycle, no stall or flush.
- Field 8'h35, valid 1 appears in stage 1, then stage 2, 3, 4 on successive edges.
REQ-024 Bubble: stall=4'b0001 for 2 cycles with 8'h5A in stage 1.
- Stage 1 keeps 8'h5A.
- Stage 2 shows valid 0, field 8'h50 for 2 cycles.
- Stage 1 advances after stall drops.
REQ-025 Flush priority: stall=4'b0010 and flush=4'b0010 in the same cycle, stage-1 entry 8'h3C.
- Stage 2 becomes valid 0, field 8'h30.
REQ-026 Multicycle: load 8'h81 with valid_d=1.
- md_busy=1 for 4 cycles; md_stall=1 for the first 3.
- Stage 1 holds 8'h81 for 4 cycles.
- Stage 2 shows 3 bubbles, then 8'h81.
- Back-to-back 8'h82 at release re-enters BUSY without an IDLE cycle.
REQ-027 Abort: flush=4'b0001 at cnt=2 of a multicycle.
- Next cycle: md_busy=0, md_stall=0, valid_q[0]=0, field 8'h80.
REQ-028 Reset mid-pipeline: rst pulsed asynchronously between edges with all stages valid and BUSY.
- All outputs read 0 immediately; the first post-release load behaves per REQ-023.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if -- bundle of the decode-side inputs and pipeline-side outputs
// of ctrl_pipe.
//   ctrl_d / valid_d : decode-stage control field and its valid
//   stall / flush    : per-stage hold and clear requests (bit k-1 = stage k)
//   ctrl_q / valid_q : registered stage fields (stage k at [k*W-1:(k-1)*W])
//   md_stall         : upstream hold while a multicycle op occupies stage 1
//   md_busy          : multicycle sequencer is busy
// master = the side that drives decode/stall/flush, slave = ctrl_pipe.
`timescale 1ns/1ps
interface ctrl_pipe_if #(
  parameter int W      = 16,
  parameter int STAGES = 4
);
  logic [W-1:0]        ctrl_d;
  logic                valid_d;
  logic [STAGES-1:0]   stall;
  logic [STAGES-1:0]   flush;
  logic [STAGES*W-1:0] ctrl_q;
  logic [STAGES-1:0]   valid_q;
  logic                md_stall;
  logic                md_busy;

  modport master (
    output ctrl_d, valid_d, stall, flush,
    input  ctrl_q, valid_q, md_stall, md_busy
  );

  modport slave (
    input  ctrl_d, valid_d, stall, flush,
    output ctrl_q, valid_q, md_stall, md_busy
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- STAGES-deep control-field pipeline with per-stage stall and
// flush, automatic bubble insertion below a held stage, and a small sequencer
// that keeps a multicycle (mul/div) entry in stage 1 for MD_CYCLES cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ctrl_pipe_if.slave (decode input, stall/flush, stage outputs,
//          md_stall / md_busy)
`timescale 1ns/1ps
module ctrl_pipe #(
  parameter int             W         = 16,
  parameter int             STAGES    = 4,
  parameter logic [W-1:0]   CLR_MASK  = {W{1'b1}},
  parameter int             MD_BIT    = 0,
  parameter int             MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_pipe_if.slave bus
);
  localparam int            CW       = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

  mdState_t                 stateReg, stateNext;
  logic [CW-1:0]            cntReg, cntNext;
  logic                     mdStall;
  logic                     mdLoad;
  logic [STAGES-1:0]        holdVec;
  logic [STAGES-1:0][W-1:0] fieldReg, fieldNext;
  logic [STAGES-1:0]        validReg, validNext;

  // The last sequencer cycle (cnt==0) releases the hold so the multicycle
  // entry leaves stage 1 on that edge.
  assign mdStall = (stateReg == BUSY) && (cntReg != '0);
  assign holdVec = bus.stall | {{(STAGES-1){1'b0}}, mdStall};

  // Stage 1 takes a real multicycle instruction from decode this edge.
  assign mdLoad = !bus.flush[0] && !holdVec[0] && bus.valid_d && bus.ctrl_d[MD_BIT];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [W-1:0] srcField;
    logic [W-1:0] baseField;
    logic         srcValid;
    logic         upHold;
    logic         clrField;

    if (gi == 0) begin : g_head
      assign srcField = bus.ctrl_d;
      assign srcValid = bus.valid_d;
      assign upHold   = 1'b0;
    end else begin : g_tail
      assign srcField = fieldReg[gi-1];
      assign srcValid = validReg[gi-1];
      assign upHold   = holdVec[gi-1];
    end

    // Unmasked bits follow the source unless this stage is held; flush and
    // the bubble below a held stage both zero the CLR_MASK bits and valid.
    assign baseField      = holdVec[gi] ? fieldReg[gi] : srcField;
    assign clrField       = bus.flush[gi] || (!holdVec[gi] && upHold);
    assign fieldNext[gi]  = clrField ? (baseField & ~CLR_MASK) : baseField;
    assign validNext[gi]  = clrField ? 1'b0 : (holdVec[gi] ? validReg[gi] : srcValid);
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (mdLoad) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        // Counting ignores stall[0]; a flush of stage 1 aborts the op.
        if (bus.flush[0]) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cntReg != '0) begin
          cntNext = cntReg - CW'(1);
        end else if (mdLoad) begin
          cntNext = CNT_LOAD;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fieldReg <= '0;
      validReg <= '0;
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      fieldReg <= fieldNext;
      validReg <= validNext;
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  assign bus.ctrl_q   = fieldReg;
  assign bus.valid_q  = validReg;
  assign bus.md_stall = mdStall;
  assign bus.md_busy  = (stateReg == BUSY);
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- directed bench for ctrl_pipe with W=8, STAGES=4,
// CLR_MASK=8'h0F, MD_BIT=7, MD_CYCLES=4. Inputs change 1 ns after the rising
// edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_ctrl_pipe;
  localparam int W = 8;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  ctrl_pipe_if #(.W(W), .STAGES(STAGES)) bus ();

  ctrl_pipe #(
    .W(W), .STAGES(STAGES), .CLR_MASK(8'h0F), .MD_BIT(7), .MD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [W-1:0] fld(input int k);
    return bus.ctrl_q[k*W-1 -: W];
  endfunction

  task automatic chkStage(input string tag, input int k, input logic [7:0] f, input logic v);
    chk($sformatf("%s s%0d field", tag, k), 32'(fld(k)), 32'(f));
    chk($sformatf("%s s%0d valid", tag, k), 32'(bus.valid_q[k-1]), 32'(v));
  endtask

  task automatic chkMd(input string tag, input logic busy, input logic stl);
    chk($sformatf("%s md_busy", tag), 32'(bus.md_busy), 32'(busy));
    chk($sformatf("%s md_stall", tag), 32'(bus.md_stall), 32'(stl));
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic [3:0] s, input logic [3:0] f);
    bus.ctrl_d  = d;
    bus.valid_d = v;
    bus.stall   = s;
    bus.flush   = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst ctrl_q", 32'(bus.ctrl_q), 32'h0);
    chk("rst valid_q", 32'(bus.valid_q), 32'h0);
    chkMd("rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // plain flow: 8'h35 walks stage 1..4
    drive(8'h35, 1'b1, 4'b0000, 4'b0000);
    tick;
    chkStage("flow", 1, 8'h35, 1'b1);
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    chkStage("flow", 2, 8'h35, 1'b1);
    chkStage("flow", 1, 8'h00, 1'b0);
    tick;
    chkStage("flow", 3, 8'h35, 1'b1);
    tick;
    chkStage("flow", 4, 8'h35, 1'b1);

    // bubble below a held stage 1
    drive(8'h5A, 1'b1, 4'b0000, 4'b0000);
    tick;
    chkStage("bub load", 1, 8'h5A, 1'b1);
    drive(8'h00, 1'b0, 4'b0001, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      tick;
      chkStage($sformatf("bub c%0d", i), 1, 8'h5A, 1'b1);
      chkStage($sformatf("bub c%0d", i), 2, 8'h50, 1'b0);
    end
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    chkStage("bub rel", 2, 8'h5A, 1'b1);
    chkStage("bub rel", 1, 8'h00, 1'b0);

    // flush beats stall on stage 2 (held bits kept, masked bits cleared)
    drive(8'h3C, 1'b1, 4'b0000, 4'b0000);
    tick;
    tick;
    chkStage("fp pre", 2, 8'h3C, 1'b1);
    drive(8'h00, 1'b0, 4'b0010, 4'b0010);
    tick;
    chkStage("fp", 2, 8'h30, 1'b0);
    chkStage("fp", 3, 8'h30, 1'b0);
    drive(8'h6B, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h3C, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h3C, 1'b1, 4'b0010, 4'b0010);
    tick;
    chkStage("fp keep", 2, 8'h60, 1'b0);
    chkStage("fp keep", 1, 8'h3C, 1'b1);

    // multicycle 8'h81 then back-to-back 8'h82
    drive(8'h81, 1'b1, 4'b0000, 4'b0000);
    tick;
    chkMd("md e0", 1'b1, 1'b1);
    chkStage("md e0", 1, 8'h81, 1'b1);
    drive(8'h82, 1'b1, 4'b0000, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      tick;
      chkMd($sformatf("md e%0d", i), 1'b1, (i < 3));
      chkStage($sformatf("md e%0d", i), 1, 8'h81, 1'b1);
      chkStage($sformatf("md e%0d", i), 2, 8'h80, 1'b0);
    end
    tick;
    chkMd("md e4", 1'b1, 1'b1);
    chkStage("md e4", 1, 8'h82, 1'b1);
    chkStage("md e4", 2, 8'h81, 1'b1);
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    tick;
    tick;
    chkMd("md e7", 1'b1, 1'b0);
    tick;
    chkMd("md e8", 1'b0, 1'b0);
    chkStage("md e8", 2, 8'h82, 1'b1);

    // abort a multicycle with flush[0] at cnt=2
    drive(8'h81, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    chkMd("ab cnt2", 1'b1, 1'b1);
    drive(8'h00, 1'b0, 4'b0000, 4'b0001);
    tick;
    chkMd("ab", 1'b0, 1'b0);
    chkStage("ab", 1, 8'h80, 1'b0);
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    chkMd("ab after", 1'b0, 1'b0);

    // asynchronous reset mid-pipeline while busy
    drive(8'h11, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h22, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h33, 1'b1, 4'b0000, 4'b0000);
    tick;
    drive(8'h84, 1'b1, 4'b0000, 4'b0000);
    tick;
    chk("mr pre valid_q", 32'(bus.valid_q), 32'hF);
    chk("mr pre ctrl_q", 32'(bus.ctrl_q), 32'h11223384);
    chkMd("mr pre", 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mr ctrl_q", 32'(bus.ctrl_q), 32'h0);
    chk("mr valid_q", 32'(bus.valid_q), 32'h0);
    chkMd("mr", 1'b0, 1'b0);
    drive(8'h35, 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chkStage("mr flow", 1, 8'h35, 1'b1);
    chkMd("mr flow", 1'b0, 1'b0);
    drive(8'h00, 1'b0, 4'b0000, 4'b0000);
    tick;
    chkStage("mr flow", 2, 8'h35, 1'b1);
    chkMd("mr flow2", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
